// File: rtl/uart_mmio_slave.sv
// Memory-mapped 8N1 UART on the CPU data bus: TXD/RXD/CON registers,
// serial transmit and receive state machines, and a level interrupt.
module uart_mmio_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h40000018,
    parameter int          BAUD_DIV  = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irqout,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Address decode and bus strobes
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (Address == BASE_ADDR);
    assign sel_rxd = (Address == BASE_ADDR + 32'd4);
    assign sel_con = (Address == BASE_ADDR + 32'd8);
    assign wr_txd  = MemWrite & sel_txd;
    assign wr_con  = MemWrite & sel_con;
    assign rd_rxd  = MemRead & sel_rxd;
    assign rd_con  = MemRead & sel_con;

    logic unused_wdata;
    assign unused_wdata = ^Write_data[31:8];

    // Register file state
    logic       tx_ie, rx_ie;
    logic       tx_done, tx_ovr;
    logic       rx_valid, rx_ovr, rx_ferr;
    logic [7:0] tx_shadow, rx_data;
    logic       tx_busy;

    // ---------------------------------------------------------------- TX
    state_t      tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_idx, tx_idx_nxt;
    logic        tx_line, tx_accept, tx_finish;

    assign tx_busy = (tx_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            uart_tx  <= tx_line;
        end
    end

    // Line level is driven from the current state, so the registered
    // output trails the state by one cycle and every bit spans BAUD_DIV.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_line      = 1'b1;
        tx_accept    = 1'b0;
        tx_finish    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (wr_txd) begin
                    tx_accept    = 1'b1;
                    tx_state_nxt = S_START;
                    tx_cnt_nxt   = '0;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_idx_nxt   = '0;
                    tx_state_nxt = S_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + 16'd1;
                end
            end
            S_DATA: begin
                tx_line = tx_shadow[tx_idx];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_idx == 3'd7) tx_state_nxt = S_STOP;
                    else                tx_idx_nxt   = tx_idx + 3'd1;
                end else begin
                    tx_cnt_nxt = tx_cnt + 16'd1;
                end
            end
            S_STOP: begin
                tx_line = 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_finish    = 1'b1;
                    tx_state_nxt = S_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + 16'd1;
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX
    logic        rx_s1, rx_s2, rx_s3;
    state_t      rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_idx, rx_idx_nxt;
    logic [7:0]  rx_shift;
    logic        rx_shift_en, rx_ok, rx_err;

    // Synchroniser resets to idle-high so release never fakes a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_idx   <= rx_idx_nxt;
            if (rx_shift_en) rx_shift <= {rx_s2, rx_shift[7:1]};
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_en  = 1'b0;
        rx_ok        = 1'b0;
        rx_err       = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    rx_state_nxt = S_START;
                    rx_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = '0;
                    rx_idx_nxt = '0;
                    rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt  = '0;
                    rx_shift_en = 1'b1;
                    if (rx_idx == 3'd7) rx_state_nxt = S_STOP;
                    else                rx_idx_nxt   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = S_IDLE;
                    rx_ok        = rx_s2;
                    rx_err       = !rx_s2;
                end else begin
                    rx_cnt_nxt = rx_cnt + 16'd1;
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------- registers
    // Clears are written before sets so a coincident event wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ie     <= 1'b0;
            rx_ie     <= 1'b0;
            tx_done   <= 1'b0;
            tx_ovr    <= 1'b0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            rx_ferr   <= 1'b0;
            tx_shadow <= '0;
            rx_data   <= '0;
            irqout    <= 1'b0;
        end else begin
            if (wr_con)    {rx_ie, tx_ie} <= Write_data[1:0];
            if (tx_accept) tx_shadow <= Write_data[7:0];

            if (rd_con) begin
                tx_done <= 1'b0;
                tx_ovr  <= 1'b0;
                rx_ovr  <= 1'b0;
                rx_ferr <= 1'b0;
            end
            if (rd_rxd) rx_valid <= 1'b0;

            if (tx_finish)          tx_done <= 1'b1;
            if (wr_txd && tx_busy)  tx_ovr  <= 1'b1;
            if (rx_err)             rx_ferr <= 1'b1;
            if (rx_ok) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rxd) rx_ovr <= 1'b1;
            end

            irqout <= (tx_ie & tx_done) | (rx_ie & rx_valid);
        end
    end

    // Single-cycle load path
    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (sel_txd)      Read_data = {24'b0, tx_shadow};
            else if (sel_rxd) Read_data = {24'b0, rx_data};
            else if (sel_con) Read_data = {24'b0, rx_ferr, rx_ovr, tx_ovr, tx_busy,
                                           rx_valid, tx_done, rx_ie, tx_ie};
        end
    end

endmodule

// File: tb/tb_uart_mmio_slave.sv
// Directed bench for uart_mmio_slave at 16 clocks per bit.
module tb_uart_mmio_slave;

    localparam logic [31:0] TXD = 32'h40000018;
    localparam logic [31:0] RXD = 32'h4000001C;
    localparam logic [31:0] CON = 32'h40000020;
    localparam int          BD  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, Write_data, Read_data;
    logic        irqout, uart_tx, uart_rx;

    int n_checks = 0;
    int n_errors = 0;

    uart_mmio_slave #(.BASE_ADDR(32'h40000018), .BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .irqout(irqout), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns at the next negedge.
    task automatic bus_op(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        MemRead    = !wr;
        MemWrite   = wr;
        Address    = addr;
        Write_data = wdata;
        #1 rdata = Read_data;
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = '0;
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit ovr,
                            input logic [31:0] con_end, input logic irq_end);
        logic [31:0] rd;
        logic [9:0]  bits;
        bit          quiet;
        bits = {1'b1, b, 1'b0};
        bus_op(1'b1, TXD, {24'b0, b}, rd);
        check("tx_before_start", uart_tx, 1);
        for (int t = 1; t <= 10 * BD; t++) begin
            if (t == 30) begin
                bus_op(1'b0, CON, 0, rd);
                check("con_busy", rd[4], 1);
            end else if (ovr && t == 40) begin
                bus_op(1'b1, TXD, 32'h3C, rd);
            end else begin
                @(negedge clk);
            end
            if (t == 1) check("tx_start_edge", uart_tx, 0);
            if (t % BD == BD / 2) check($sformatf("tx_bit%0d", t / BD), uart_tx, bits[t / BD]);
        end
        check("irq_not_yet", irqout, 0);
        repeat (2) @(negedge clk);
        check("irq_tx_done", irqout, irq_end);
        bus_op(1'b0, CON, 0, rd);
        check("con_after_tx", rd, con_end);
        repeat (2) @(negedge clk);
        check("irq_after_con", irqout, 0);
        if (ovr) begin
            quiet = 1'b1;
            for (int i = 0; i < 4 * BD; i++) begin
                @(negedge clk);
                if (uart_tx !== 1'b1) quiet = 1'b0;
            end
            check("ovr_not_sent", quiet, 1);
            bus_op(1'b0, TXD, 0, rd);
            check("txd_last_accepted", rd, {24'b0, b});
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (BD) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; Write_data = '0; uart_rx = 1'b1;

        // reset and idle
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_irq", irqout, 0);
        MemRead = 1'b1; Address = CON;
        #1 check("rst_con_comb", Read_data, 0);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_op(1'b0, CON, 0, rd);
        check("con_idle", rd, 0);
        bus_op(1'b0, 32'h40000024, 0, rd);
        check("unmapped_rd", rd, 0);
        Address = TXD;
        #1 check("no_memread", Read_data, 0);
        @(negedge clk);

        // transmit, then transmit with overrun
        bus_op(1'b1, CON, 32'h1, rd);
        tx_frame(8'hA5, 1'b0, 32'h05, 1'b1);
        tx_frame(8'hA5, 1'b1, 32'h25, 1'b1);

        // good receive
        bus_op(1'b1, CON, 32'h2, rd);
        rx_send(8'h5A, 1'b1);
        check("rx_irq", irqout, 1);
        bus_op(1'b0, CON, 0, rd);
        check("rx_con_valid", rd, 32'h0A);
        bus_op(1'b0, RXD, 0, rd);
        check("rx_data", rd, 32'h5A);
        repeat (2) @(negedge clk);
        check("rx_irq_clr", irqout, 0);
        bus_op(1'b0, CON, 0, rd);
        check("rx_valid_clr", rd, 32'h02);

        // glitch rejection
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BD) @(negedge clk);
        bus_op(1'b0, CON, 0, rd);
        check("glitch_con", rd, 32'h02);
        check("glitch_irq", irqout, 0);

        // framing error
        rx_send(8'h33, 1'b0);
        bus_op(1'b0, CON, 0, rd);
        check("ferr_con", rd, 32'h82);
        bus_op(1'b0, CON, 0, rd);
        check("ferr_clr", rd, 32'h02);

        // receive overrun
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        bus_op(1'b0, CON, 0, rd);
        check("ovr_con", rd, 32'h4A);
        bus_op(1'b0, RXD, 0, rd);
        check("ovr_data", rd, 32'h22);

        // reset in the middle of a transmit data bit
        bus_op(1'b1, TXD, 32'h00, rd);
        repeat (40) @(negedge clk);
        check("tx_mid_low", uart_tx, 0);
        reset = 1'b0;
        #1 check("rst_mid_tx", uart_tx, 1);
        MemRead = 1'b1; Address = CON;
        #1 check("rst_mid_con", Read_data, 0);
        MemRead = 1'b0; Address = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tx_frame(8'hC3, 1'b0, 32'h04, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
